// File: rtl/counter_ctrl.sv
// counter_ctrl: start/stop/pause run controller counting 0..limit, one-shot or periodic.
// Define COUNTER_CTRL_PRESCALE_EN to step once every PRESCALE clocks instead of every clock.
module counter_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);
  // state | meaning
  // IDLE  | inactive, count held at 0
  // RUN   | stepping from 0 toward limit
  // HOLD  | paused, count and prescaler frozen
  // DONE  | one-shot run finished, sticky until start or stop
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] limit;
  logic             mode;
  logic             run_active;
  logic             step;
  logic             terminal;

  if (PRESCALE < 2 || PRESCALE > 255) begin : g_prescale_range
    $error("counter_ctrl: PRESCALE must be within 2..255");
  end

  // A step can only happen in RUN on an edge where no higher-priority input acts.
  assign run_active = (state_q == S_RUN) && !stop && !start && !pause;
  assign terminal   = step && (count == limit);

`ifdef COUNTER_CTRL_PRESCALE_EN
  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);
  logic [7:0] presc;

  assign step = run_active && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (stop || start) begin
      presc <= '0;
    end else if (run_active) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 8'd1;
    end
  end
`else
  assign step = run_active;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (pause) begin
            state_d = S_HOLD;
          end else if (terminal && !mode) begin
            state_d = S_DONE;
          end
        end
        S_HOLD: begin
          if (!pause) begin
            state_d = S_RUN;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    state = state_q;
    busy  = (state_q == S_RUN) || (state_q == S_HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      done  <= 1'b0;
      limit <= '0;
      mode  <= 1'b0;
    end else if (stop) begin
      count <= '0;
      done  <= 1'b0;
    end else if (start) begin
      count <= '0;
      done  <= 1'b0;
      limit <= load_val;
      mode  <= auto_reload;
    end else begin
      done <= terminal;
      if (terminal) begin
        count <= '0;
      end else if (step) begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed scenarios plus randomized traffic, checked every cycle
// against a progress-count reference model (count = steps taken mod (limit+1)).
module tb_counter_ctrl;
  localparam int WIDTH    = 4;
  localparam int PRESCALE = 4;
`ifdef COUNTER_CTRL_PRESCALE_EN
  localparam int STEP_CLKS = PRESCALE;
`else
  localparam int STEP_CLKS = 1;
`endif
  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_HOLD = 2;
  localparam int ST_DONE = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  int n_checks = 0;
  int n_bad    = 0;

  int m_state;
  int m_limit;
  int m_ticks;
  int m_presc;
  bit m_periodic;
  bit m_done;

  counter_ctrl #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .auto_reload (auto_reload),
    .load_val    (load_val),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state    = ST_IDLE;
    m_limit    = 0;
    m_ticks    = 0;
    m_presc    = 0;
    m_periodic = 1'b0;
    m_done     = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit pa, input bit ar, input int lv);
    m_done = 1'b0;
    if (sp) begin
      m_state = ST_IDLE;
      m_ticks = 0;
      m_presc = 0;
    end else if (st) begin
      m_state    = ST_RUN;
      m_limit    = lv % (1 << WIDTH);
      m_periodic = ar;
      m_ticks    = 0;
      m_presc    = 0;
    end else if (m_state == ST_RUN && pa) begin
      m_state = ST_HOLD;
    end else if (m_state == ST_HOLD) begin
      if (!pa) m_state = ST_RUN;
    end else if (m_state == ST_RUN) begin
      m_presc++;
      if (m_presc == STEP_CLKS) begin
        m_presc = 0;
        m_ticks++;
        if (m_ticks % (m_limit + 1) == 0) begin
          m_done = 1'b1;
          if (!m_periodic) begin
            m_state = ST_DONE;
            m_ticks = 0;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    check_val("count", count, m_ticks % (m_limit + 1));
    check_val("state", state, m_state);
    check_val("busy", busy, (m_state == ST_RUN || m_state == ST_HOLD) ? 1 : 0);
    check_val("done", done, m_done);
  endtask

  task automatic run_cycle(input bit st, input bit sp, input bit pa, input bit ar, input int lv);
    start       = st;
    stop        = sp;
    pause       = pa;
    auto_reload = ar;
    load_val    = WIDTH'(lv);
    @(posedge clk);
    model_edge(st, sp, pa, ar, lv);
    #1;
    check_model();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int dones;
    bit rnd_pause;
    int rnd_lv;

    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    auto_reload = 1'b0; load_val = '0;
    #1 reset = 1'b0;
    model_reset();
    #1;
    check_val("rst_count", count, 0);
    check_val("rst_state", state, ST_IDLE);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_hold_state", state, ST_IDLE);
    start = 1'b0;
    #3 reset = 1'b1;

    // one-shot, limit 5
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 5);
    for (int k = 1; k <= 6 * STEP_CLKS; k++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
      if (k == 5 * STEP_CLKS) check_val("oneshot_peak", count, 5);
    end
    check_val("oneshot_done", done, 1);
    check_val("oneshot_state", state, ST_DONE);
    idle_cycles(3);
    check_val("oneshot_sticky", state, ST_DONE);
    check_val("oneshot_pulse", done, 0);

    // periodic, limit 3
    run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 3);
    dones = 0;
    for (int k = 1; k <= 12 * STEP_CLKS; k++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
      if (done) dones++;
      if (k % (4 * STEP_CLKS) == 0) check_val("periodic_done", done, 1);
    end
    check_val("periodic_count3", dones, 3);
    check_val("periodic_busy", busy, 1);

    // pause at count 4, limit 9
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 9);
    idle_cycles(4 * STEP_CLKS);
    check_val("pause_pre", count, 4);
    for (int k = 0; k < 3; k++) begin
      run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
      check_val("pause_state", state, ST_HOLD);
      check_val("pause_count", count, 4);
    end
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_val("resume_state", state, ST_RUN);
    check_val("resume_count", count, 4);
    idle_cycles(STEP_CLKS);
    check_val("resume_step", count, 5);
    idle_cycles(5 * STEP_CLKS - 1);
    check_val("pause_pre_done", done, 0);
    idle_cycles(1);
    check_val("pause_late_done", done, 1);

    // priority
    run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 10);
    idle_cycles(7 * STEP_CLKS);
    check_val("prio_at7", count, 7);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 10);
    check_val("prio_stop_state", state, ST_IDLE);
    check_val("prio_stop_count", count, 0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1);
    idle_cycles(2 * STEP_CLKS);
    check_val("prio_in_done", state, ST_DONE);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 4);
    check_val("prio_restart", state, ST_RUN);

    // full-range wrap
    run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 15);
    idle_cycles(15 * STEP_CLKS);
    check_val("wrap_top", count, 15);
    idle_cycles(STEP_CLKS);
    check_val("wrap_zero", count, 0);
    check_val("wrap_done", done, 1);
    check_val("wrap_state", state, ST_RUN);

    // limit 0, periodic then one-shot
    run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 0);
    for (int k = 0; k < 3; k++) begin
      idle_cycles(STEP_CLKS);
      check_val("lim0_done", done, 1);
    end
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(STEP_CLKS);
    check_val("lim0_oneshot", state, ST_DONE);

    // asynchronous reset mid-run at count 6
    run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 12);
    idle_cycles(6 * STEP_CLKS);
    check_val("arst_pre", count, 6);
    #3 reset = 1'b0;
    #1;
    check_val("arst_count", count, 0);
    check_val("arst_state", state, ST_IDLE);
    check_val("arst_busy", busy, 0);
    check_val("arst_done", done, 0);
    model_reset();
    start = 1'b1;
    @(posedge clk);
    #1;
    check_val("arst_ignore", state, ST_IDLE);
    start = 1'b0;
    #3 reset = 1'b1;
    idle_cycles(2);

    // randomized traffic
    rnd_pause = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(4, 0) == 0) rnd_pause = ~rnd_pause;
      case ($urandom_range(3, 0))
        0: rnd_lv = 0;
        1: rnd_lv = 15;
        default: rnd_lv = $urandom_range(15, 0);
      endcase
      run_cycle($urandom_range(19, 0) == 0, $urandom_range(39, 0) == 0, rnd_pause,
                1'($urandom_range(1, 0)), rnd_lv);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
